axi_read_responder: RTL and testbench
=====================================

Name: axi_read_responder

Overview:
- Terminating end of the AXI read path: accepts AR bursts from the AR buffer and issues one single-beat read request per beat to the bridge's APB-side port.
- Returns each beat's data on the AXI R channel with RID, RUSER, RRESP and RLAST.
- Keeps one burst and one beat in flight at a time; all sequencing and burst address generation happen here.

Parameters:
ID_WIDTH  4  AR/R ID width
ADDR_WIDTH  32  address width
DATA_WIDTH  32  R data width (8..1024, power of two)
USER_WIDTH  1  AR/R user width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
ar_valid_i  in  1  AR valid
ar_addr_i  in  ADDR_WIDTH  burst start address
ar_len_i  in  8  beats-1
ar_size_i  in  3  bytes per beat = 1<<size
ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
ar_id_i  in  ID_WIDTH  transaction ID
ar_user_i  in  USER_WIDTH  user sideband
ar_ready_o  out  1  AR ready
rd_req_valid_o  out  1  beat read request valid
rd_req_addr_o  out  ADDR_WIDTH  beat address
rd_req_ready_i  in  1  request accepted
rd_rsp_valid_i  in  1  beat response valid
rd_rsp_data_i  in  DATA_WIDTH  beat read data
rd_rsp_err_i  in  1  beat error
rd_rsp_ready_o  out  1  response accepted
r_valid_o  out  1  R valid
r_data_o  out  DATA_WIDTH  R data
r_resp_o  out  2  00 OKAY, 10 SLVERR
r_last_o  out  1  final beat
r_id_o  out  ID_WIDTH  latched ar_id_i
r_user_o  out  USER_WIDTH  latched ar_user_i
r_ready_i  in  1  R ready

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk_i, reset port is rst_ni.
- Reset: FSM to IDLE. ar_ready_o=1. rd_req_valid_o, rd_rsp_ready_o, r_valid_o and r_last_o are 0. All data, address, ID, user and resp outputs are 0.
- Reset mid-burst aborts the in-flight beat; no R beat is emitted for it.
- All handshake outputs are registered.
- FSM states: IDLE, REQ, RSP, SEND, ERR.
- IDLE:
  - ar_ready_o=1.
  - On ar_valid_i&&ar_ready_o: latch addr, len, size, burst, id and user; clear beat counter.
  - Next state is REQ if the burst is legal, else ERR.
- Illegal burst, any of:
  - ar_burst_i=11.
  - (1<<ar_size_i) > DATA_WIDTH/8.
  - WRAP with len not in {1,3,7,15}.
- REQ: rd_req_valid_o=1 with the current beat address; held stable until rd_req_ready_i. On handshake go to RSP.
- RSP:
  - rd_rsp_ready_o=1.
  - On rd_rsp_valid_i: capture data; resp = err ? 10 : 00; go to SEND.
  - A response arriving in the same cycle as the request handshake is not sampled; it is sampled from the next cycle.
- SEND:
  - r_valid_o=1; r_last_o = (count==len).
  - data, resp and last are held stable while r_ready_i=0.
  - On handshake: if last, go to IDLE (ar_ready_o=1 the next cycle); else advance address, count+1, go to REQ.
- ERR:
  - Emits len+1 R beats with r_data_o=0 and r_resp_o=10; r_last_o set on the final beat.
  - No rd_req is issued.
  - Back-to-back beats when r_ready_i=1; returns to IDLE after the last handshake.
- Latency, zero-wait peers: AR handshake at cycle N → rd_req_valid_o at N+1 → response sampled at N+3 at the earliest → r_valid_o at N+4.
- Address update, with bytes = 1<<size:
  - FIXED: address unchanged.
  - INCR: next = (addr & ~(bytes-1)) + bytes. An unaligned start is aligned from beat 2 onward.
  - WRAP: mask = ((len+1)*bytes)-1; next = (addr & ~mask) | ((addr+bytes) & mask).
  - All arithmetic is modulo 2^ADDR_WIDTH. 4KB crossing is not checked (master responsibility).
- No new AR is accepted until the final R beat of the current burst handshakes.

Test Plan:
- Reset, then single beat: AR addr=0x100, len=0, size=2, INCR, id=5; APB data 0xDEADBEEF → one rd_req at 0x100; R data=0xDEADBEEF, resp=00, last=1, id=5; ar_ready_o=1 in the cycle after.
- INCR, unaligned start: addr=0x1002, len=3, size=2 → rd_req addrs 0x1002, 0x1004, 0x1008, 0x100C; last only on beat 4.
- WRAP: addr=0x38, len=3, size=2 → rd_req addrs 0x38, 0x3C, 0x30, 0x34. FIXED: addr=0x20, len=2 → 0x20 ×3.
- Error paths:
  - rd_rsp_err_i=1 on beat 2 of a 3-beat INCR → resps 00, 10, 00; burst completes.
  - ar_burst_i=11, len=1 → no rd_req; two R beats with data 0 and resp 10, last on beat 2.
- Backpressure: random r_ready_i and rd_req_ready_i stalls on an 8-beat burst → R outputs stable while stalled, no beat lost or duplicated, ar_ready_o=0 for the whole burst.
- Reset asserted while in RSP → all outputs return to reset values immediately; a fresh AR after reset completes correctly.

Source files
------------

// File: rtl/axi_read_responder.sv
// AXI read terminator: turns each AR burst into single-beat read requests
// and returns every beat on R with ID, USER, RESP and LAST.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   ar_*                               AR channel (valid/ready, burst fields)
//   rd_req_valid_o/addr_o/ready_i      one read request per beat
//   rd_rsp_valid_i/data_i/err_i/ready_o  read response for that beat
//   r_*                                R channel (valid/ready, data/resp/last/id/user)
module axi_read_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ar_valid_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic [2:0]            ar_size_i,
    input  logic [1:0]            ar_burst_i,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [USER_WIDTH-1:0] ar_user_i,
    output logic                  ar_ready_o,
    output logic                  rd_req_valid_o,
    output logic [ADDR_WIDTH-1:0] rd_req_addr_o,
    input  logic                  rd_req_ready_i,
    input  logic                  rd_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] rd_rsp_data_i,
    input  logic                  rd_rsp_err_i,
    output logic                  rd_rsp_ready_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [USER_WIDTH-1:0] r_user_o,
    input  logic                  r_ready_i
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RSP,
        SEND,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            resp_q, resp_d;

    logic ar_ready_q, ar_ready_d;
    logic req_valid_q, req_valid_d;
    logic rsp_ready_q, rsp_ready_d;
    logic r_valid_q, r_valid_d;
    logic r_last_q, r_last_d;

    logic                  size_ok;
    logic                  wrap_ok;
    logic                  legal;
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0] next_addr;

    always_comb begin
        size_ok = int'(ar_size_i) <= MAX_SIZE;
        wrap_ok = (ar_len_i == 8'd1) || (ar_len_i == 8'd3) ||
                  (ar_len_i == 8'd7) || (ar_len_i == 8'd15);
        legal   = (ar_burst_i != 2'b11) && size_ok &&
                  ((ar_burst_i != 2'b10) || wrap_ok);
    end

    // Wrap window is (len+1)*bytes, always a power of two for legal bursts.
    always_comb begin
        bytes = ADDR_WIDTH'(1) << size_q;
        wmask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q)
                - ADDR_WIDTH'(1);
        unique case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wmask) |
                                 ((addr_q + bytes) & wmask);
            default: next_addr = (addr_q & ~(bytes - ADDR_WIDTH'(1)))
                                 + bytes;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        id_d    = id_q;
        user_d  = user_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        resp_d  = resp_q;

        unique case (state_q)
            IDLE: begin
                if (ar_valid_i && ar_ready_q) begin
                    addr_d  = ar_addr_i;
                    len_d   = ar_len_i;
                    size_d  = ar_size_i;
                    burst_d = ar_burst_i;
                    id_d    = ar_id_i;
                    user_d  = ar_user_i;
                    cnt_d   = 8'd0;
                    data_d  = '0;
                    resp_d  = legal ? 2'b00 : 2'b10;
                    state_d = legal ? REQ : ERR;
                end
            end
            REQ: begin
                if (req_valid_q && rd_req_ready_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                // rsp_ready_q rises one cycle after entry, so a response
                // coincident with the request handshake is never taken.
                if (rd_rsp_valid_i && rsp_ready_q) begin
                    data_d  = rd_rsp_data_i;
                    resp_d  = rd_rsp_err_i ? 2'b10 : 2'b00;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (r_valid_q && r_ready_i) begin
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = next_addr;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = REQ;
                    end
                end
            end
            ERR: begin
                if (r_valid_q && r_ready_i) begin
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ar_ready_d  = (state_d == IDLE);
        req_valid_d = (state_d == REQ);
        rsp_ready_d = (state_q == RSP) && (state_d == RSP);
        r_valid_d   = (state_d == SEND) || (state_d == ERR);
        r_last_d    = r_valid_d && (cnt_d == len_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            id_q        <= '0;
            user_q      <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            resp_q      <= '0;
            ar_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            r_valid_q   <= 1'b0;
            r_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            id_q        <= id_d;
            user_q      <= user_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            resp_q      <= resp_d;
            ar_ready_q  <= ar_ready_d;
            req_valid_q <= req_valid_d;
            rsp_ready_q <= rsp_ready_d;
            r_valid_q   <= r_valid_d;
            r_last_q    <= r_last_d;
        end
    end

    assign ar_ready_o     = ar_ready_q;
    assign rd_req_valid_o = req_valid_q;
    assign rd_req_addr_o  = addr_q;
    assign rd_rsp_ready_o = rsp_ready_q;
    assign r_valid_o      = r_valid_q;
    assign r_data_o       = data_q;
    assign r_resp_o       = resp_q;
    assign r_last_o       = r_last_q;
    assign r_id_o         = id_q;
    assign r_user_o       = user_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: table of AR bursts with expected beat
// addresses, a read-port peer model and an R-channel scoreboard.
module tb_axi_read_responder;

    localparam int NV = 12;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ar_valid_i = 1'b0;
    logic [31:0] ar_addr_i = '0;
    logic [7:0]  ar_len_i = '0;
    logic [2:0]  ar_size_i = '0;
    logic [1:0]  ar_burst_i = '0;
    logic [3:0]  ar_id_i = '0;
    logic [0:0]  ar_user_i = '0;
    logic        ar_ready_o;
    logic        rd_req_valid_o;
    logic [31:0] rd_req_addr_o;
    logic        rd_req_ready_i = 1'b0;
    logic        rd_rsp_valid_i = 1'b0;
    logic [31:0] rd_rsp_data_i = '0;
    logic        rd_rsp_err_i = 1'b0;
    logic        rd_rsp_ready_o;
    logic        r_valid_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic [3:0]  r_id_o;
    logic [0:0]  r_user_o;
    logic        r_ready_i = 1'b0;

    axi_read_responder dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .ar_valid_i     (ar_valid_i),
        .ar_addr_i      (ar_addr_i),
        .ar_len_i       (ar_len_i),
        .ar_size_i      (ar_size_i),
        .ar_burst_i     (ar_burst_i),
        .ar_id_i        (ar_id_i),
        .ar_user_i      (ar_user_i),
        .ar_ready_o     (ar_ready_o),
        .rd_req_valid_o (rd_req_valid_o),
        .rd_req_addr_o  (rd_req_addr_o),
        .rd_req_ready_i (rd_req_ready_i),
        .rd_rsp_valid_i (rd_rsp_valid_i),
        .rd_rsp_data_i  (rd_rsp_data_i),
        .rd_rsp_err_i   (rd_rsp_err_i),
        .rd_rsp_ready_o (rd_rsp_ready_o),
        .r_valid_o      (r_valid_o),
        .r_data_o       (r_data_o),
        .r_resp_o       (r_resp_o),
        .r_last_o       (r_last_o),
        .r_id_o         (r_id_o),
        .r_user_o       (r_user_o),
        .r_ready_i      (r_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        logic        user;
        int          err_beat;
        bit          stall;
        bit          legal;
        logic [31:0] d0;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        logic        user;
    } rb_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } pk_t;

    vec_t        vs [NV];
    logic [31:0] ea [NV][8];

    rb_t         exp_r [$];
    logic [31:0] exp_req [$];
    pk_t         peer_q [$];
    pk_t         pend [$];
    int          req_cycs [$];
    int          r_cycs [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_ar_cyc = 0;
    bit stall = 1'b0;
    bit hold_rsp = 1'b0;

    bit   chk_ar_next = 1'b0;
    bit   pv_r = 1'b0;
    bit   pv_q = 1'b0;
    rb_t  sv_r;
    logic [31:0] sv_a;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Read-port peer, R sink and scoreboard; everything is sampled and
    // driven at the falling edge so the DUT sees stable inputs.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_r.delete();
            exp_req.delete();
            peer_q.delete();
            pend.delete();
            rd_req_ready_i = 1'b0;
            rd_rsp_valid_i = 1'b0;
            rd_rsp_data_i  = '0;
            rd_rsp_err_i   = 1'b0;
            r_ready_i      = 1'b0;
            chk_ar_next    = 1'b0;
            pv_r           = 1'b0;
            pv_q           = 1'b0;
        end else begin
            if (pv_r) begin
                chk("stall_r_valid", r_valid_o, 1);
                chk("stall_r_data", r_data_o, sv_r.data);
                chk("stall_r_resp", r_resp_o, sv_r.resp);
                chk("stall_r_last", r_last_o, sv_r.last);
            end
            if (pv_q) begin
                chk("stall_req_valid", rd_req_valid_o, 1);
                chk("stall_req_addr", rd_req_addr_o, sv_a);
            end
            if (chk_ar_next) begin
                chk("ar_ready_after", ar_ready_o, 1);
                chk_ar_next = 1'b0;
            end else if (exp_r.size() != 0) begin
                chk("ar_ready_busy", ar_ready_o, 0);
            end

            if (pend.size() != 0 && !hold_rsp) begin
                rd_rsp_valid_i = 1'b1;
                rd_rsp_data_i  = pend[0].data;
                rd_rsp_err_i   = pend[0].err;
            end else begin
                rd_rsp_valid_i = 1'b0;
                rd_rsp_data_i  = '0;
                rd_rsp_err_i   = 1'b0;
            end
            rd_req_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            r_ready_i      = stall ? 1'($urandom_range(0, 1)) : 1'b1;

            if (rd_rsp_valid_i && rd_rsp_ready_o) void'(pend.pop_front());

            if (rd_req_valid_o && rd_req_ready_i) begin
                req_cycs.push_back(cyc);
                if (exp_req.size() == 0 || peer_q.size() == 0) begin
                    chk("unexpected_req", rd_req_addr_o, 64'hx);
                end else begin
                    chk("req_addr", rd_req_addr_o, exp_req.pop_front());
                    pend.push_back(peer_q.pop_front());
                end
            end

            if (r_valid_o && r_ready_i) begin
                r_cycs.push_back(cyc);
                if (exp_r.size() == 0) begin
                    chk("unexpected_r", r_data_o, 64'hx);
                end else begin
                    rb_t e;
                    e = exp_r.pop_front();
                    chk("r_data", r_data_o, e.data);
                    chk("r_resp", r_resp_o, e.resp);
                    chk("r_last", r_last_o, e.last);
                    chk("r_id", r_id_o, e.id);
                    chk("r_user", r_user_o, e.user);
                    if (e.last && exp_r.size() == 0) chk_ar_next = 1'b1;
                end
            end

            pv_r = r_valid_o && !r_ready_i;
            sv_r = '{r_data_o, r_resp_o, r_last_o, r_id_o, r_user_o};
            pv_q = rd_req_valid_o && !rd_req_ready_i;
            sv_a = rd_req_addr_o;
        end
    end

    task automatic send_burst(input int vi);
        vec_t v;
        int   k;
        v = vs[vi];
        @(negedge clk);
        ar_valid_i = 1'b1;
        ar_addr_i  = v.addr;
        ar_len_i   = v.len;
        ar_size_i  = v.size;
        ar_burst_i = v.burst;
        ar_id_i    = v.id;
        ar_user_i  = v.user;
        k = 0;
        while (!ar_ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!ar_ready_o) begin
            chk("ar_timeout", 0, 1);
            ar_valid_i = 1'b0;
            return;
        end
        last_ar_cyc = cyc;
        @(posedge clk);
        #1;
        for (int i = 0; i <= int'(v.len); i++) begin
            logic [31:0] d;
            bit          er;
            d  = (i == 0) ? v.d0 : $urandom;
            er = (i == v.err_beat);
            if (v.legal) begin
                exp_req.push_back(ea[vi][i]);
                peer_q.push_back('{d, er});
                exp_r.push_back('{d, er ? 2'b10 : 2'b00, i == int'(v.len),
                                  v.id, v.user});
            end else begin
                exp_r.push_back('{32'h0, 2'b10, i == int'(v.len),
                                  v.id, v.user});
            end
        end
        @(negedge clk);
        ar_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_r.size() != 0 || exp_req.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (exp_r.size() != 0 || exp_req.size() != 0)
            chk("burst_timeout", exp_r.size(), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outs();
        chk("rst_ar_ready", ar_ready_o, 1);
        chk("rst_req_valid", rd_req_valid_o, 0);
        chk("rst_rsp_ready", rd_rsp_ready_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_last", r_last_o, 0);
        chk("rst_outs_zero",
            {rd_req_addr_o, r_data_o, r_resp_o, r_id_o, r_user_o}, 0);
    endtask

    initial begin
        vs[0]  = '{32'h100, 8'd0, 3'd2, 2'b01, 4'd5, 1'b0, -1, 0, 1,
                   32'hDEADBEEF};
        vs[1]  = '{32'h1002, 8'd3, 3'd2, 2'b01, 4'd1, 1'b1, -1, 0, 1, 32'h11};
        vs[2]  = '{32'h38, 8'd3, 3'd2, 2'b10, 4'd2, 1'b0, -1, 0, 1, 32'h22};
        vs[3]  = '{32'h20, 8'd2, 3'd2, 2'b00, 4'd3, 1'b1, -1, 0, 1, 32'h33};
        vs[4]  = '{32'h200, 8'd2, 3'd2, 2'b01, 4'd4, 1'b0, 1, 0, 1, 32'h44};
        vs[5]  = '{32'h300, 8'd1, 3'd2, 2'b11, 4'd6, 1'b1, -1, 0, 0, 32'h0};
        vs[6]  = '{32'h0, 8'd0, 3'd3, 2'b01, 4'd7, 1'b0, -1, 0, 0, 32'h0};
        vs[7]  = '{32'h40, 8'd2, 3'd2, 2'b10, 4'd8, 1'b0, -1, 0, 0, 32'h0};
        vs[8]  = '{32'h45, 8'd7, 3'd0, 2'b10, 4'd9, 1'b1, -1, 0, 1, 32'h88};
        vs[9]  = '{32'h3, 8'd1, 3'd1, 2'b01, 4'hA, 1'b0, -1, 0, 1, 32'h99};
        vs[10] = '{32'hFFFFFFFC, 8'd1, 3'd2, 2'b01, 4'hB, 1'b0, -1, 0, 1,
                   32'hAA};
        vs[11] = '{32'h400, 8'd7, 3'd2, 2'b01, 4'hC, 1'b1, 3, 1, 1, 32'hBB};
        ea = '{
            '{32'h100, 0, 0, 0, 0, 0, 0, 0},
            '{32'h1002, 32'h1004, 32'h1008, 32'h100C, 0, 0, 0, 0},
            '{32'h38, 32'h3C, 32'h30, 32'h34, 0, 0, 0, 0},
            '{32'h20, 32'h20, 32'h20, 0, 0, 0, 0, 0},
            '{32'h200, 32'h204, 32'h208, 0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0},
            '{32'h45, 32'h46, 32'h47, 32'h40, 32'h41, 32'h42, 32'h43, 32'h44},
            '{32'h3, 32'h4, 0, 0, 0, 0, 0, 0},
            '{32'hFFFFFFFC, 32'h0, 0, 0, 0, 0, 0, 0},
            '{32'h400, 32'h404, 32'h408, 32'h40C,
              32'h410, 32'h414, 32'h418, 32'h41C}
        };

        #12;
        chk_reset_outs();
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            stall = vs[i].stall;
            send_burst(i);
            wait_done();
            stall = 1'b0;
            if (i == 0) begin
                chk("lat_req", req_cycs.size() ? req_cycs[0] - last_ar_cyc
                                               : -1, 1);
                chk("lat_r", r_cycs.size() ? r_cycs[0] - last_ar_cyc
                                           : -1, 4);
            end
        end

        // Abort a burst while the DUT waits for a read response.
        hold_rsp = 1'b1;
        send_burst(1);
        begin
            int k;
            k = 0;
            while (!rd_rsp_ready_o && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("reach_rsp", rd_rsp_ready_o, 1);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_outs();
        @(negedge clk);
        @(negedge clk);
        hold_rsp = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("no_r_after_rst", r_valid_o, 0);

        send_burst(2);
        wait_done();
        send_burst(0);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
